hpi_responder: RTL and testbench

Cycle-accurate responder model of the CY7C67200 Host Port Interface (HPI), the peer of the FPGA-side HPI bus driver. It decodes the OTG_* strobes from the host side and serves four HPI registers: DATA, MAILBOX, ADDRESS and STATUS. Behind them sit a word-addressed on-chip memory and a pair of mailboxes. It drives OTG_INT and exposes a device-side port that stands in for the USB chip's firmware, so keyboard-polling software can run in simulation and in loop-back builds without the physical chip.

---
 rtl/hpi_responder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_hpi_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hpi_responder.sv
// -----------------------------------------------------------------------------
// hpi_responder
//
// This module models the host-port side of a CY7C67200 USB controller. An FPGA
// HPI bus driver can talk to it as though the real chip were present. The host
// reaches four registers through the OTG_* strobes:
//   DATA    (0) : auto-incrementing window into a 16-bit word memory
//   MAILBOX (1) : read = device-to-host message, write = host-to-device message
//   ADDRESS (2) : byte address used by DATA accesses
//   STATUS  (3) : {14'b0, dev_mbx_valid, out_full}
// A device-side port stands in for the chip firmware. It has the two
// mailboxes and a backdoor memory port.
//
// Ports
//   Clk, Reset          : clock and synchronous active-high reset
//   OTG_ADDR[1:0]       : register select
//   OTG_CS_N/RD_N/WR_N  : active-low chip select, read and write strobes
//   OTG_DATA_in[15:0]   : host write data
//   OTG_DATA_out[15:0]  : read data, valid the cycle after a read start
//   OTG_DATA_oe         : high while the responder drives the bus
//   OTG_INT             : device-to-host mailbox full
//   dev_mbx_wdata/wr    : device loads the outgoing mailbox
//   dev_mbx_rdata/valid : last host message and its full flag
//   dev_mbx_ack         : device consumes the host message
//   mem_addr/we/wdata   : backdoor memory port (AW-bit word address)
//   mem_rdata           : backdoor read data, one cycle after mem_addr
// -----------------------------------------------------------------------------
module hpi_responder #(
  parameter int MEM_WORDS = 256,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [1:0]    OTG_ADDR,
  input  logic          OTG_CS_N,
  input  logic          OTG_RD_N,
  input  logic          OTG_WR_N,
  input  logic [15:0]   OTG_DATA_in,
  output logic [15:0]   OTG_DATA_out,
  output logic          OTG_DATA_oe,
  output logic          OTG_INT,
  input  logic [15:0]   dev_mbx_wdata,
  input  logic          dev_mbx_wr,
  output logic [15:0]   dev_mbx_rdata,
  output logic          dev_mbx_valid,
  input  logic          dev_mbx_ack,
  input  logic [AW-1:0] mem_addr,
  input  logic          mem_we,
  input  logic [15:0]   mem_wdata,
  output logic [15:0]   mem_rdata
);

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_MAILBOX = 2'd1;
  localparam logic [1:0] REG_ADDRESS = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // ---------------------------------------------------------------------------
  // Input pipeline. s1 is the first register stage for the pins. s2 holds the
  // previous s1 values, so strobe edges can be found from s1/s2 alone.
  // ---------------------------------------------------------------------------
  logic        cs1_q, rd1_q, wr1_q;
  logic [1:0]  addr1_q;
  logic [15:0] data1_q;
  logic        cs2_q, rd2_q, wr2_q;
  logic [1:0]  addr2_q;
  logic [15:0] data2_q;

  logic        cs1_d, rd1_d, wr1_d;
  logic [1:0]  addr1_d;
  logic [15:0] data1_d;
  logic        cs2_d, rd2_d, wr2_d;
  logic [1:0]  addr2_d;
  logic [15:0] data2_d;

  always_comb begin
    cs1_d   = OTG_CS_N;
    rd1_d   = OTG_RD_N;
    wr1_d   = OTG_WR_N;
    addr1_d = OTG_ADDR;
    data1_d = OTG_DATA_in;
    cs2_d   = cs1_q;
    rd2_d   = rd1_q;
    wr2_d   = wr1_q;
    addr2_d = addr1_q;
    data2_d = data1_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cs1_q   <= 1'b1;
      rd1_q   <= 1'b1;
      wr1_q   <= 1'b1;
      addr1_q <= 2'd0;
      data1_q <= 16'd0;
      cs2_q   <= 1'b1;
      rd2_q   <= 1'b1;
      wr2_q   <= 1'b1;
      addr2_q <= 2'd0;
      data2_q <= 16'd0;
    end else begin
      cs1_q   <= cs1_d;
      rd1_q   <= rd1_d;
      wr1_q   <= wr1_d;
      addr1_q <= addr1_d;
      data1_q <= data1_d;
      cs2_q   <= cs2_d;
      rd2_q   <= rd2_d;
      wr2_q   <= wr2_d;
      addr2_q <= addr2_d;
      data2_q <= data2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer events. If both strobes are low on the relevant stage, the cycle
  // is a bus conflict, and neither a read nor a write is taken. For a read,
  // the stage is s1. For a write, it is the stage of the last low WR sample,
  // which is s2. Both events are suppressed while Reset is high, so an
  // in-flight access is dropped.
  // ---------------------------------------------------------------------------
  logic rd_start;
  logic wr_end;

  always_comb begin
    rd_start = !Reset && !cs1_q && !rd1_q && rd2_q && wr1_q;
    wr_end   = !Reset && !cs2_q && !wr2_q && wr1_q && rd2_q;
  end

  logic rd_data, rd_mbx;
  logic wr_data, wr_mbx, wr_addr;

  always_comb begin
    rd_data = rd_start && (addr1_q == REG_DATA);
    rd_mbx  = rd_start && (addr1_q == REG_MAILBOX);
    wr_data = wr_end   && (addr2_q == REG_DATA);
    wr_mbx  = wr_end   && (addr2_q == REG_MAILBOX);
    wr_addr = wr_end   && (addr2_q == REG_ADDRESS);
  end

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic [15:0] hpi_addr_q,   hpi_addr_d;
  logic [15:0] out_mbx_q,    out_mbx_d;
  logic        out_full_q,   out_full_d;
  logic [15:0] in_mbx_q,     in_mbx_d;
  logic        in_valid_q,   in_valid_d;
  logic [15:0] reg_rdata_q,  reg_rdata_d;
  logic        rd_mem_sel_q, rd_mem_sel_d;
  logic        oe_q,         oe_d;

  logic [AW-1:0] host_idx;
  assign host_idx = hpi_addr_q[AW:1];

  always_comb begin
    hpi_addr_d   = hpi_addr_q;
    out_mbx_d    = out_mbx_q;
    out_full_d   = out_full_q;
    in_mbx_d     = in_mbx_q;
    in_valid_d   = in_valid_q;
    reg_rdata_d  = reg_rdata_q;
    rd_mem_sel_d = rd_mem_sel_q;
    oe_d         = !cs1_q && !rd1_q;

    // Writing ADDRESS takes priority over the DATA auto-increment. The 16-bit
    // add wraps naturally from 0xFFFE to 0x0000.
    if (wr_addr) begin
      hpi_addr_d = data2_q;
    end else if (rd_data || wr_data) begin
      hpi_addr_d = hpi_addr_q + 16'd2;
    end

    // A device load in the same cycle as the host read keeps the flag set.
    // The host still sees the old message, because reg_rdata_d below takes
    // out_mbx_q and not out_mbx_d.
    if (dev_mbx_wr) begin
      out_mbx_d  = dev_mbx_wdata;
      out_full_d = 1'b1;
    end else if (rd_mbx) begin
      out_full_d = 1'b0;
    end

    // A host write beats a device ack in the same cycle.
    if (wr_mbx) begin
      in_mbx_d   = data2_q;
      in_valid_d = 1'b1;
    end else if (dev_mbx_ack) begin
      in_valid_d = 1'b0;
    end

    // Read data from memory comes back through host_rdata_q, one cycle later.
    // Read data from any other register is captured here. rd_mem_sel picks
    // the source for the output mux.
    if (rd_start) begin
      rd_mem_sel_d = (addr1_q == REG_DATA);
      unique case (addr1_q)
        REG_MAILBOX: reg_rdata_d = out_mbx_q;
        REG_ADDRESS: reg_rdata_d = hpi_addr_q;
        REG_STATUS:  reg_rdata_d = {14'd0, in_valid_q, out_full_q};
        default:     reg_rdata_d = reg_rdata_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hpi_addr_q   <= 16'd0;
      out_mbx_q    <= 16'd0;
      out_full_q   <= 1'b0;
      in_mbx_q     <= 16'd0;
      in_valid_q   <= 1'b0;
      reg_rdata_q  <= 16'd0;
      rd_mem_sel_q <= 1'b0;
      oe_q         <= 1'b0;
    end else begin
      hpi_addr_q   <= hpi_addr_d;
      out_mbx_q    <= out_mbx_d;
      out_full_q   <= out_full_d;
      in_mbx_q     <= in_mbx_d;
      in_valid_q   <= in_valid_d;
      reg_rdata_q  <= reg_rdata_d;
      rd_mem_sel_q <= rd_mem_sel_d;
      oe_q         <= oe_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Word memory with two ports. The host port reads and writes through
  // hpi_addr. The backdoor port reads every cycle and writes on mem_we. Reads
  // are registered and return the pre-write contents. When both ports write
  // the same word, the backdoor write is masked so that the host value lands.
  // ---------------------------------------------------------------------------
  logic [15:0] mem [MEM_WORDS];
  logic [15:0] host_rdata_q;
  logic [15:0] mem_rdata_q;
  logic        bd_we;

  assign bd_we = mem_we && !(wr_data && (mem_addr == host_idx));

  always_ff @(posedge Clk) begin
    if (bd_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (wr_data) begin
      mem[host_idx] <= data2_q;
    end
    if (rd_data) begin
      host_rdata_q <= mem[host_idx];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem_rdata_q <= 16'd0;
    end else begin
      mem_rdata_q <= mem[mem_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign OTG_DATA_out  = rd_mem_sel_q ? host_rdata_q : reg_rdata_q;
  assign OTG_DATA_oe   = oe_q;
  assign OTG_INT       = out_full_q;
  assign dev_mbx_rdata = in_mbx_q;
  assign dev_mbx_valid = in_valid_q;
  assign mem_rdata     = mem_rdata_q;

endmodule

// File: tb/tb_hpi_responder.sv
// -----------------------------------------------------------------------------
// tb_hpi_responder
//
// Directed test of hpi_responder using host strobe sequences, the device
// mailbox port and the backdoor memory port. Inputs change on the falling
// clock edge and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_hpi_responder;

  localparam int MEM_WORDS = 256;
  localparam int AW        = 8;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [1:0]    OTG_ADDR;
  logic          OTG_CS_N, OTG_RD_N, OTG_WR_N;
  logic [15:0]   OTG_DATA_in;
  logic [15:0]   OTG_DATA_out;
  logic          OTG_DATA_oe;
  logic          OTG_INT;
  logic [15:0]   dev_mbx_wdata;
  logic          dev_mbx_wr;
  logic [15:0]   dev_mbx_rdata;
  logic          dev_mbx_valid;
  logic          dev_mbx_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  hpi_responder #(.MEM_WORDS(MEM_WORDS)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .OTG_ADDR     (OTG_ADDR),
    .OTG_CS_N     (OTG_CS_N),
    .OTG_RD_N     (OTG_RD_N),
    .OTG_WR_N     (OTG_WR_N),
    .OTG_DATA_in  (OTG_DATA_in),
    .OTG_DATA_out (OTG_DATA_out),
    .OTG_DATA_oe  (OTG_DATA_oe),
    .OTG_INT      (OTG_INT),
    .dev_mbx_wdata(dev_mbx_wdata),
    .dev_mbx_wr   (dev_mbx_wr),
    .dev_mbx_rdata(dev_mbx_rdata),
    .dev_mbx_valid(dev_mbx_valid),
    .dev_mbx_ack  (dev_mbx_ack),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%04h expected=0x%04h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%04h", tag, got);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Holds WR_N low for 2 cycles, then waits long enough for the commit.
  task automatic hpi_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge Clk);
    OTG_ADDR = a; OTG_DATA_in = d; OTG_CS_N = 1'b0; OTG_WR_N = 1'b0;
    idle(2);
    OTG_WR_N = 1'b1; OTG_CS_N = 1'b1;
    idle(4);
  endtask

  // Holds RD_N low for 4 cycles and samples at the end of the strobe.
  task automatic hpi_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge Clk);
    OTG_ADDR = a; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
    idle(4);
    d = OTG_DATA_out;
    check16("oe_during_read", {15'd0, OTG_DATA_oe}, 16'd1);
    OTG_RD_N = 1'b1; OTG_CS_N = 1'b1;
    idle(3);
  endtask

  task automatic bd_read(input logic [AW-1:0] a, output logic [15:0] d);
    @(negedge Clk);
    mem_addr = a;
    @(negedge Clk);
    d = mem_rdata;
  endtask

  logic [15:0] rv;

  initial begin
    Reset = 1'b1;
    OTG_ADDR = 2'd0; OTG_CS_N = 1'b1; OTG_RD_N = 1'b1; OTG_WR_N = 1'b1;
    OTG_DATA_in = 16'd0;
    dev_mbx_wdata = 16'd0; dev_mbx_wr = 1'b0; dev_mbx_ack = 1'b0;
    mem_addr = '0; mem_we = 1'b0; mem_wdata = 16'd0;
    idle(3);

    // Reset values
    check16("rst_data_out", OTG_DATA_out, 16'h0000);
    check16("rst_oe", {15'd0, OTG_DATA_oe}, 16'd0);
    check16("rst_int", {15'd0, OTG_INT}, 16'd0);
    check16("rst_mbx_valid", {15'd0, dev_mbx_valid}, 16'd0);
    check16("rst_mbx_rdata", dev_mbx_rdata, 16'h0000);
    check16("rst_mem_rdata", mem_rdata, 16'h0000);
    Reset = 1'b0;
    idle(2);
    hpi_read(2'd2, rv);  check16("rst_hpi_addr", rv, 16'h0000);

    // ADDRESS write and readback, with no increment
    hpi_write(2'd2, 16'h0010);
    hpi_read(2'd2, rv);  check16("addr_rb1", rv, 16'h0010);
    hpi_read(2'd2, rv);  check16("addr_rb2", rv, 16'h0010);

    // DATA auto-increment
    hpi_write(2'd0, 16'hBEEF);
    hpi_write(2'd0, 16'hCAFE);
    hpi_read(2'd2, rv);  check16("addr_after_wr", rv, 16'h0014);
    bd_read(8'd8, rv);   check16("bd_mem8", rv, 16'hBEEF);
    bd_read(8'd9, rv);   check16("bd_mem9", rv, 16'hCAFE);
    hpi_write(2'd2, 16'h0010);
    hpi_read(2'd0, rv);  check16("data_rd0", rv, 16'hBEEF);
    hpi_read(2'd0, rv);  check16("data_rd1", rv, 16'hCAFE);
    hpi_read(2'd2, rv);  check16("addr_after_rd", rv, 16'h0014);

    // Address wrap
    hpi_write(2'd2, 16'hFFFE);
    hpi_write(2'd0, 16'h1234);
    hpi_read(2'd2, rv);  check16("addr_wrap", rv, 16'h0000);
    bd_read(8'd255, rv); check16("bd_mem255", rv, 16'h1234);

    // Backdoor write, then read through the host
    @(negedge Clk);
    mem_addr = 8'd3; mem_wdata = 16'h3333; mem_we = 1'b1;
    @(negedge Clk);
    mem_we = 1'b0;
    hpi_write(2'd2, 16'h0006);
    hpi_read(2'd0, rv);  check16("host_rd_bd_word", rv, 16'h3333);

    // Device-to-host mailbox
    @(negedge Clk);
    dev_mbx_wdata = 16'h00A5; dev_mbx_wr = 1'b1;
    @(negedge Clk);
    dev_mbx_wr = 1'b0;
    check16("int_after_dev_wr", {15'd0, OTG_INT}, 16'd1);
    hpi_read(2'd3, rv);  check16("status_out_full", rv, 16'h0001);
    hpi_read(2'd1, rv);  check16("mbx_read", rv, 16'h00A5);
    check16("int_after_mbx_rd", {15'd0, OTG_INT}, 16'd0);
    hpi_read(2'd3, rv);  check16("status_empty", rv, 16'h0000);

    // Host-to-device mailbox
    hpi_write(2'd1, 16'h5A5A);
    check16("h2d_valid1", {15'd0, dev_mbx_valid}, 16'd1);
    check16("h2d_rdata1", dev_mbx_rdata, 16'h5A5A);
    hpi_read(2'd3, rv);  check16("status_in_valid", rv, 16'h0002);
    hpi_write(2'd1, 16'h1111);
    check16("h2d_valid2", {15'd0, dev_mbx_valid}, 16'd1);
    check16("h2d_rdata2", dev_mbx_rdata, 16'h1111);
    @(negedge Clk);
    dev_mbx_ack = 1'b1;
    @(negedge Clk);
    dev_mbx_ack = 1'b0;
    check16("h2d_valid_ack", {15'd0, dev_mbx_valid}, 16'd0);
    hpi_read(2'd3, rv);  check16("status_after_ack", rv, 16'h0000);

    // Reset while a DATA write strobe is low
    @(negedge Clk);
    mem_addr = 8'd16; mem_wdata = 16'h7777; mem_we = 1'b1;
    @(negedge Clk);
    mem_we = 1'b0;
    hpi_write(2'd2, 16'h0020);
    @(negedge Clk);
    OTG_ADDR = 2'd0; OTG_DATA_in = 16'hDEAD; OTG_CS_N = 1'b0; OTG_WR_N = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    OTG_WR_N = 1'b1; OTG_CS_N = 1'b1;
    idle(2);
    Reset = 1'b0;
    idle(4);
    bd_read(8'd16, rv);  check16("rst_midwr_mem", rv, 16'h7777);
    hpi_read(2'd2, rv);  check16("rst_midwr_addr", rv, 16'h0000);

    // dev_mbx_wr in the same cycle as a MAILBOX read start
    @(negedge Clk);
    dev_mbx_wdata = 16'h0011; dev_mbx_wr = 1'b1;
    @(negedge Clk);
    dev_mbx_wr = 1'b0;
    idle(1);
    OTG_ADDR = 2'd1; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;      // RD falls
    @(negedge Clk);                                         // s1 low, s2 high: read start
    dev_mbx_wdata = 16'h0022; dev_mbx_wr = 1'b1;
    @(negedge Clk);
    dev_mbx_wr = 1'b0;
    idle(2);
    check16("coll_old_value", OTG_DATA_out, 16'h0011);
    OTG_RD_N = 1'b1; OTG_CS_N = 1'b1;
    idle(3);
    check16("coll_int_stays", {15'd0, OTG_INT}, 16'd1);
    hpi_read(2'd1, rv);  check16("coll_new_value", rv, 16'h0022);
    check16("coll_int_clear", {15'd0, OTG_INT}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
